// File: rtl/data_cache_unpacker_if.sv
// Handshake bundle for the cached-word unpacker: one wide input word stream and
// one channel-tagged 32-bit output stream.
interface data_cache_unpacker_if #(
    parameter int DATA_W = 32,
    parameter int N_CH   = 4,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH*DATA_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_chan;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/data_cache_unpacker.sv
// Serializes the populated 32-bit sections of a cached word onto a channel-tagged stream.
// Optional saturating count of dropped all-empty words: DATA_CACHE_UNPACKER_DROP_CNT_EN.
//
//   state | meaning
//   IDLE  | ready for a new cached word; nothing presented downstream
//   EMIT  | presenting the lowest pending lane of the buffered word
module data_cache_unpacker #(
    parameter int DATA_W    = 32,
    parameter int N_CH      = 4,
    parameter int SKIP_ZERO = 1
) (
    input  logic clk,
    input  logic reset,
    data_cache_unpacker_if.slave bus
`ifdef DATA_CACHE_UNPACKER_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                 state, state_nxt;
    logic [N_CH*DATA_W-1:0] data_buf;
    logic [N_CH-1:0]        mask;
    logic [N_CH-1:0]        in_mask;
    logic [N_CH-1:0]        mask_rem;
    logic [CH_W-1:0]        lane_sel;
    logic [DATA_W-1:0]      lane_data;
    logic                   accept;

    always_comb begin
        in_mask = '0;
        for (int k = 0; k < N_CH; k++) begin
            in_mask[k] = (SKIP_ZERO == 0) || (bus.in_data[k*DATA_W +: DATA_W] != '0);
        end
    end

    // Walk downward so the lowest pending lane wins; keeps lane order ascending.
    always_comb begin
        lane_sel  = '0;
        lane_data = data_buf[DATA_W-1:0];
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lane_sel  = CH_W'(k);
                lane_data = data_buf[k*DATA_W +: DATA_W];
            end
        end
    end

    assign mask_rem      = mask & ~(N_CH'(1) << lane_sel);
    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == EMIT);
    assign bus.out_chan  = lane_sel;
    assign bus.out_data  = lane_data;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && (in_mask != '0)) state_nxt = EMIT;
            EMIT: if (bus.out_ready && (mask_rem == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            data_buf <= '0;
            mask     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_buf <= bus.in_data;
                mask     <= in_mask;
            end else if ((state == EMIT) && bus.out_ready) begin
                mask <= mask_rem;
            end
        end
    end

`ifdef DATA_CACHE_UNPACKER_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (accept && (in_mask == '0) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_data_cache_unpacker.sv
// Scoreboard bench for data_cache_unpacker: one instance with empty-lane skipping,
// one emitting every lane.
module tb_data_cache_unpacker;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [33:0] exp_q[$];
    logic [33:0] exp0_q[$];

    data_cache_unpacker_if #(.DATA_W(32), .N_CH(4)) bus ();
    data_cache_unpacker_if #(.DATA_W(32), .N_CH(4)) bus0 ();

`ifdef DATA_CACHE_UNPACKER_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt0;
`endif

    data_cache_unpacker #(.DATA_W(32), .N_CH(4), .SKIP_ZERO(1)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef DATA_CACHE_UNPACKER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    data_cache_unpacker #(.DATA_W(32), .N_CH(4), .SKIP_ZERO(0)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus0)
`ifdef DATA_CACHE_UNPACKER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt0)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every completed output handshake.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got chan=%0d data=%h, expected no output",
                         bus.out_chan, bus.out_data);
            end else begin
                check("out_skip", {30'd0, bus.out_chan, bus.out_data}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (bus0.out_valid && bus0.out_ready) begin
            if (exp0_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out0: got chan=%0d data=%h, expected no output",
                         bus0.out_chan, bus0.out_data);
            end else begin
                check("out_noskip", {30'd0, bus0.out_chan, bus0.out_data}, {30'd0, exp0_q.pop_front()});
            end
        end
    end

    // Returns at accept-edge + 1; expected non-empty lanes are queued first.
    task automatic send1(input logic [127:0] w);
        int t;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (w[k*32 +: 32] != 32'd0) exp_q.push_back({2'(k), w[k*32 +: 32]});
        end
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus0.in_data   = '0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_chan", 64'(bus.out_chan), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        idle_cycles(1);

        // Four populated lanes, full throughput
        send1({32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", 64'(bus.out_valid), 64'd1);
            check("t1_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("t1_chan", 64'(bus.out_chan), 64'(i));
        end
        @(negedge clk);
        check("t1_idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("t1_idle_valid", 64'(bus.out_valid), 64'd0);
        idle_cycles(2);

        // Single populated lane
        send1({32'h0, 32'h12345678, 32'h0, 32'h0});
        @(negedge clk);
        check("t2_chan", 64'(bus.out_chan), 64'd2);
        check("t2_data", 64'(bus.out_data), 64'h12345678);
        idle_cycles(4);

        // All-empty words back to back
        bus.in_data  = '0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_in_ready", 64'(bus.in_ready), 64'd1);
            check("t3_no_valid", 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t3_after_valid", 64'(bus.out_valid), 64'd0);
`ifdef DATA_CACHE_UNPACKER_DROP_CNT_EN
        check("t3_drop_cnt", 64'(drop_cnt), 64'd3);
`endif
        idle_cycles(2);

        // Backpressure: lanes 0 and 3, ready low for 5 cycles
        bus.out_ready = 1'b0;
        send1({32'h33330000, 32'h0, 32'h0, 32'h11110000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
            check("t4_hold_chan", 64'(bus.out_chan), 64'd0);
            check("t4_hold_data", 64'(bus.out_data), 64'h11110000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t4_rel_chan", 64'(bus.out_chan), 64'd0);
        @(negedge clk);
        check("t4_lane3_chan", 64'(bus.out_chan), 64'd3);
        check("t4_lane3_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        check("t4_done_valid", 64'(bus.out_valid), 64'd0);
        idle_cycles(2);

        // Reset while lane 1 is presented
        send1({32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001});
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("t5_lane1_chan", 64'(bus.out_chan), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", 64'(bus.out_valid), 64'd0);
        check("t5_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("t5_lane0_consumed", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t5_rel_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (6) begin
            @(negedge clk);
            check("t5_no_resume", 64'(bus.out_valid), 64'd0);
        end
        idle_cycles(1);

        // No skipping: an all-zero word yields four zero sections in order
        bus0.in_data  = '0;
        bus0.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) exp0_q.push_back({2'(k), 32'h0});
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("t6_valid", 64'(bus0.out_valid), 64'd1);
        check("t6_first_chan", 64'(bus0.out_chan), 64'd0);

        t = 0;
        while ((exp_q.size() != 0 || exp0_q.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        idle_cycles(3);
        check("drain_q_skip", 64'(exp_q.size()), 64'd0);
        check("drain_q_noskip", 64'(exp0_q.size()), 64'd0);
        check("t6_end_in_ready", 64'(bus0.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
